// File: rtl/nor_arb_pkg.sv
// Shared encodings and defaults for the shared NOR arbiter.
package nor_arb_pkg;

  localparam int unsigned NReqDefault = 4;
  localparam int unsigned WDefault    = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StAck  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IdxW-1:0]  win_idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % N_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_oh_o[cand]  = 1'b1;
        win_idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/nor_share_arb.sv
// N requesters share one registered NOR unit; round-robin grant, 3-cycle transaction.
module nor_share_arb
  import nor_arb_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned W     = WDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       y,
  output logic               busy
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;

  logic [N_REQ-1:0] win_oh;
  logic [IdxW-1:0]  win_idx;
  logic [W-1:0]     sel_a, sel_b;

  rr_pick #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_rr_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // One-hot mux of the winner's operand slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        sel_a = op_a[i*W +: W];
        sel_b = op_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      StIdle: begin
        gnt_d = '0;
        ack_d = '0;
        y_d   = '0;
        if (|req) begin
          gnt_d   = win_oh;
          idx_d   = win_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = StBusy;
        end
      end
      StBusy: begin
        y_d     = ~(a_q | b_q);
        ack_d   = gnt_q;
        state_d = StAck;
      end
      StAck: begin
        gnt_d   = '0;
        ack_d   = '0;
        y_d     = '0;
        ptr_d   = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        ack_d   = '0;
        y_d     = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign y    = y_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_nor_share_arb.sv
// Two arbiters (W=1 and W=8) in lockstep against a transaction-level reference model.
module tb_nor_share_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   op_a1, op_b1;
  logic [N*8-1:0] op_a8, op_b8;
  logic [N-1:0]   gnt1, ack1, gnt8, ack8;
  logic [0:0]     y1;
  logic [7:0]     y8;
  logic           busy1, busy8;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: transaction phase 0 idle, 1 granted, 2 acking.
  int         m_phase = 0;
  int         m_win   = 0;
  int         m_ptr   = 0;
  logic       m_a1, m_b1;
  logic [7:0] m_a8, m_b8;

  always #5 clk = ~clk;

  nor_share_arb #(.N_REQ(N), .W(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .op_a (op_a1),
    .op_b (op_b1),
    .gnt  (gnt1),
    .ack  (ack1),
    .y    (y1),
    .busy (busy1)
  );

  nor_share_arb #(.N_REQ(N), .W(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .op_a (op_a8),
    .op_b (op_b8),
    .gnt  (gnt8),
    .ack  (ack8),
    .y    (y8),
    .busy (busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          m_win   = rr_winner(req, m_ptr);
          m_a1    = op_a1[m_win];
          m_b1    = op_b1[m_win];
          m_a8    = op_a8[m_win*8 +: 8];
          m_b8    = op_b8[m_win*8 +: 8];
          m_phase = 1;
        end
        1: m_phase = 2;
        default: begin
          m_ptr   = (m_win + 1) % N;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic model_check();
    logic [N-1:0] oh, e_gnt, e_ack;
    logic         e_y1;
    logic [7:0]   e_y8;
    oh = '0;
    oh[m_win] = 1'b1;
    e_gnt = (m_phase != 0) ? oh : '0;
    e_ack = (m_phase == 2) ? oh : '0;
    e_y1  = (m_phase == 2) ? ~(m_a1 | m_b1) : 1'b0;
    e_y8  = (m_phase == 2) ? ~(m_a8 | m_b8) : 8'h00;
    chk("m_gnt1", 32'(gnt1), 32'(e_gnt));
    chk("m_ack1", 32'(ack1), 32'(e_ack));
    chk("m_y1", 32'(y1), 32'(e_y1));
    chk("m_busy1", 32'(busy1), 32'(m_phase != 0));
    chk("m_gnt8", 32'(gnt8), 32'(e_gnt));
    chk("m_ack8", 32'(ack8), 32'(e_ack));
    chk("m_y8", 32'(y8), 32'(e_y8));
    chk("m_busy8", 32'(busy8), 32'(m_phase != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  initial begin
    int exp_ack[5] = '{1, 2, 4, 8, 1};
    int n_ack, last_cyc;

    rst = 1'b1; req = '0;
    op_a1 = '0; op_b1 = '0; op_a8 = '0; op_b8 = '0;
    step(); step();
    chk("rst_gnt", 32'(gnt1), 0);
    chk("rst_busy", 32'(busy1), 0);
    rst = 1'b0;
    step();

    // Single request, zero operands.
    req = 4'b0001;
    step();
    chk("single_gnt", 32'(gnt1), 32'h1);
    step();
    chk("single_ack", 32'(ack1), 32'h1);
    chk("single_y", 32'(y1), 32'h1);
    req = '0;
    step();
    chk("single_idle", 32'(busy1), 0);

    // Truth table from requester 2; 8-bit instance sees F0/0C.
    op_a8 = 32'h00F0_0000;
    op_b8 = 32'h000C_0000;
    for (int i = 0; i < 4; i++) begin
      req   = 4'b0100;
      op_a1 = ((i & 2) != 0) ? 4'b0100 : 4'b0000;
      op_b1 = ((i & 1) != 0) ? 4'b0100 : 4'b0000;
      step(); step();
      chk("tt_ack", 32'(ack1), 32'h4);
      chk("tt_y", 32'(y1), (i == 0) ? 32'h1 : 32'h0);
      chk("w8_y", 32'(y8), 32'h03);
      req = '0;
      step();
    end

    // Full contention from ptr=0.
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b1111;
    n_ack = 0; last_cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      op_a1 = 4'($urandom); op_b1 = 4'($urandom);
      op_a8 = $urandom; op_b8 = $urandom;
      step();
      if (ack1 != '0) begin
        if (n_ack < 5) chk("contend_ack", 32'(ack1), 32'(exp_ack[n_ack]));
        if (n_ack > 0) chk("contend_gap", 32'(c - last_cyc), 3);
        last_cyc = c;
        n_ack++;
      end
    end
    chk("contend_count", 32'(n_ack), 5);
    req = '0;
    step();

    // Operand change after grant does not affect result.
    req = 4'b0010; op_a1 = 4'b0010; op_b1 = '0;
    step();
    op_a1 = '0;
    step();
    chk("stable_ack", 32'(ack1), 32'h2);
    chk("stable_y", 32'(y1), 0);
    req = '0;
    step();

    // Reset during BUSY aborts.
    req = 4'b0100;
    step();
    rst = 1'b1;
    step();
    chk("abort_gnt", 32'(gnt1), 0);
    chk("abort_ack", 32'(ack1), 0);
    chk("abort_busy", 32'(busy1), 0);
    rst = 1'b0; req = 4'b1000;
    step();
    chk("after_rst_gnt", 32'(gnt1), 32'h8);
    step();
    chk("after_rst_ack", 32'(ack1), 32'h8);
    req = '0;
    step();

    // Reset in the ACK cycle wins over the ptr update.
    req = 4'b0010;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b1111;
    step();
    chk("ptr_reset_gnt", 32'(gnt1), 32'h1);
    step(); step();

    // Randomised traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 39) == 0);
      req   = 4'($urandom_range(0, 15));
      op_a1 = 4'($urandom); op_b1 = 4'($urandom);
      op_a8 = $urandom; op_b8 = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
